mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Select-line sequencer and sampler that sits directly upstream of the 4:1 gate-level mux (mux4).
- Drives the mux select pair s1/s0 through channels 0..3 (c1..c4).
- Waits a programmable settle time on each channel, then samples the mux output x.
- Assembles the four samples into a 4-bit word and presents it with a one-cycle valid pulse.
- Replaces hand-driven select stimulus with a clocked start/busy/valid handshake.

Parameters:
SETTLE_CYC, 1, cycles held on each channel before sampling; legal range 1..15.
CNT_W, 4, settle counter width; must hold SETTLE_CYC.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  scan request; sampled only in IDLE
abort  input  1  cancels a scan in progress
mux_x  input  1  mux output x, from mux4
s1  output  1  mux select MSB
s0  output  1  mux select LSB
busy  output  1  high while scanning (SETTLE/SAMPLE)
valid  output  1  one-cycle pulse; sample updated this cycle
sample  output  4  sample[i] = x captured with channel i selected

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset state on the clk edge with rst=1:
  - FSM=IDLE, channel index ch=0, {s1,s0}=00.
  - busy=0, valid=0, sample=4'b0000, settle counter=0.
  - rst overrides all other inputs.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy=0.
  - start=1 and abort=0 at an edge -> SETTLE, ch=0, {s1,s0}=00, counter=SETTLE_CYC-1.
- SETTLE:
  - busy=1; {s1,s0}=ch.
  - Counter decrements each cycle; counter==0 at the edge -> SAMPLE.
- SAMPLE:
  - busy=1; one cycle.
  - At the edge, work[ch] <= mux_x.
  - If ch==3 -> DONE, and sample <= {mux_x, work[2:0]}.
  - Otherwise ch <= ch+1, {s1,s0} updates to the new ch, counter=SETTLE_CYC-1, -> SETTLE.
- DONE:
  - valid=1 and busy=0 for exactly one cycle, then IDLE.
  - {s1,s0} returns to 00 on entering IDLE.
- Select mapping: ch0->00 (c1), ch1->01 (c2), ch2->10 (c3), ch3->11 (c4).
- Latency: start accepted at edge k -> valid high in cycle k+4*(SETTLE_CYC+1)+1 (9 cycles after the start edge for SETTLE_CYC=1).
- sample is held stable between valid pulses and changes only on the edge entering DONE.
- start while busy or in DONE: ignored, not queued.
- abort in SETTLE/SAMPLE: -> IDLE at the next edge; no valid pulse; sample keeps its prior value; ch=0.
- abort together with start in IDLE: abort wins, no scan.
- abort in DONE: ignored; the valid pulse still occurs.
- start held high continuously: a new scan begins in the cycle after DONE returns to IDLE (back-to-back, one IDLE cycle between scans).
- mux_x is assumed settled by the sample edge; the block has no synchroniser.

Optional Feature:
MUX_SCAN_CHANGE_EN
- Defined:
  - Adds output port changed (1 bit), registered alongside valid.
  - changed=1 during the valid cycle iff the new sample differs from the previously published sample (the reset value 0000 counts as previous).
  - changed is 0 in all other cycles; reset value 0.
- Undefined: the changed port and its compare register are absent; all other behaviour is identical.

Decomposition:
- Shared include file mux_scan_defs.vh holds:
  - FSM state encodings: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - Channel count constant NCH=4.
- One sub-module: scan_settle_cnt, a loadable down-counter with load/dec/zero flag, parameterised by CNT_W.
- The FSM, channel index and sample assembly stay in mux_scan_ctrl.

Test Plan:
1. Bench models mux4 with c1..c4=1,0,1,0 and SETTLE_CYC=1; pulse start -> {s1,s0} steps 00,01,10,11 holding 2 cycles each; valid pulse 9 cycles after the start edge; sample=4'b0101; busy drops at valid.
2. Same setup, then c1..c4 changed to 0,1,1,0 and a second start -> sample=4'b0110.
   - With MUX_SCAN_CHANGE_EN: changed=1 on both scans.
   - A third scan with unchanged inputs -> changed=0.
3. Assert abort during the ch2 SETTLE -> IDLE next cycle; no valid; sample still 4'b0101; a following start scans normally from ch0.
4. start and abort high together in IDLE -> no busy, {s1,s0} stays 00; start pulsed again mid-scan -> ignored, exactly one valid.
5. start held high for 30 cycles with SETTLE_CYC=3 -> valid every 18 cycles (16 scan + DONE + IDLE).
6. rst asserted mid-scan (ch1 SAMPLE) -> at the next edge all outputs are at reset values; sample=0000 even though a previous scan completed.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux4 select-line scan controller.
package mux_scan_ctrl_pkg;

  localparam int unsigned NCH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

endpackage

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// Loadable down-counter timing how long each mux channel is held before sampling.
module scan_settle_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_count = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps mux4 selects through channels 0..3, samples x on each, publishes a 4-bit word.
// Optional build macro MUX_SCAN_CHANGE_EN adds the 'changed' output.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_x,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       valid,
`ifdef MUX_SCAN_CHANGE_EN
  output logic       changed,
`endif
  output logic [3:0] sample
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC - 1);
  localparam logic [1:0]       LAST_CH  = 2'(NCH - 1);

  scan_state_t      r_state;
  scan_state_t      w_next;
  logic [1:0]       r_ch;
  logic [2:0]       r_work;
  logic [3:0]       r_sample;
  logic             r_valid;
  logic             w_load;
  logic             w_dec;
  logic             w_zero;
  logic             w_last;
  logic             w_publish;
  logic [3:0]       w_new_sample;
  logic [CNT_W-1:0] w_count;

  scan_settle_cnt #(
    .CNT_W(CNT_W)
  ) u_settle_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_dec     (w_dec),
    .i_load_val(LOAD_VAL),
    .o_count   (w_count),
    .o_zero    (w_zero)
  );

  assign w_last       = (r_ch == LAST_CH);
  assign w_new_sample = {mux_x, r_work};
  assign w_publish    = (r_state == SAMPLE) && (w_next == DONE);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_dec  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_next = SETTLE;
          w_load = 1'b1;
        end
      end
      SETTLE: begin
        if (abort)       w_next = IDLE;
        else if (w_zero) w_next = SAMPLE;
        else             w_dec  = 1'b1;
      end
      SAMPLE: begin
        if (abort) begin
          w_next = IDLE;
        end else if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = SETTLE;
          w_load = 1'b1;
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ch     <= '0;
      r_work   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= w_publish;
      if (w_next == IDLE) begin
        r_ch <= '0;
      end else if ((r_state == SAMPLE) && (w_next == SETTLE)) begin
        r_ch <= r_ch + 1'b1;
      end
      // Channel 3's bit goes straight into the published word, so only 0..2 are staged.
      if ((r_state == SAMPLE) && !abort) begin
        for (int unsigned i = 0; i < NCH - 1; i++) begin
          if (r_ch == 2'(i)) r_work[i] <= mux_x;
        end
      end
      if (w_publish) r_sample <= w_new_sample;
    end
  end

`ifdef MUX_SCAN_CHANGE_EN
  logic r_changed;

  always_ff @(posedge clk) begin
    if (rst) r_changed <= 1'b0;
    else     r_changed <= w_publish && (w_new_sample != r_sample);
  end

  assign changed = r_changed;
`endif

  assign {s1, s0} = r_ch;
  assign busy     = (r_state == SETTLE) || (r_state == SAMPLE);
  assign valid    = r_valid;
  assign sample   = r_sample;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl with a behavioural mux4 model.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, start3, abort3;
  logic [3:0] c, c3;
  logic       s1, s0, busy, valid, mux_x;
  logic       s1_3, s0_3, busy3, valid3, mux_x3;
  logic [3:0] sample, sample3;
`ifdef MUX_SCAN_CHANGE_EN
  logic       changed, changed3;
`endif
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // c[0] is c1 (select 00) ... c[3] is c4 (select 11)
  assign mux_x  = c[{s1, s0}];
  assign mux_x3 = c3[{s1_3, s0_3}];

  mux_scan_ctrl #(.SETTLE_CYC(1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mux_x(mux_x),
    .s1(s1), .s0(s0), .busy(busy), .valid(valid),
`ifdef MUX_SCAN_CHANGE_EN
    .changed(changed),
`endif
    .sample(sample)
  );

  mux_scan_ctrl #(.SETTLE_CYC(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3), .mux_x(mux_x3),
    .s1(s1_3), .s0(s0_3), .busy(busy3), .valid(valid3),
`ifdef MUX_SCAN_CHANGE_EN
    .changed(changed3),
`endif
    .sample(sample3)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    c = 4'b0101; c3 = 4'b1001;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({s1, s0, busy, valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {s1, s0, busy, valid});
    end
    n_assert++;
    if (sample !== 4'b0000) begin
      n_fail++; $display("FAIL reset_sample: got %b expected 0000", sample);
    end
    n_assert++;
    if ({s1_3, s0_3, busy3, valid3, sample3} !== 8'h00) begin
      n_fail++; $display("FAIL reset_dut3: got %h expected 00", {s1_3, s0_3, busy3, valid3, sample3});
    end
`ifdef MUX_SCAN_CHANGE_EN
    n_assert++;
    if (changed !== 1'b0) begin
      n_fail++; $display("FAIL reset_changed: got %b expected 0", changed);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic run_scan(input logic [3:0] exp_sample, input logic exp_chg);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      n_assert++;
      if ({s1, s0, busy, valid} !== {2'(j / 2), 2'b10}) begin
        n_fail++;
        $display("FAIL scan_step%0d: sel/busy/valid got %b expected %b", j, {s1, s0, busy, valid}, {2'(j / 2), 2'b10});
      end
      @(negedge clk);
    end
    n_assert++;
    if ({valid, busy} !== 2'b10) begin
      n_fail++; $display("FAIL scan_done: valid/busy got %b expected 10", {valid, busy});
    end
    n_assert++;
    if (sample !== exp_sample) begin
      n_fail++; $display("FAIL scan_sample: got %b expected %b", sample, exp_sample);
    end
`ifdef MUX_SCAN_CHANGE_EN
    n_assert++;
    if (changed !== exp_chg) begin
      n_fail++; $display("FAIL scan_changed: got %b expected %b", changed, exp_chg);
    end
`endif
    @(negedge clk);
    n_assert++;
    if ({s1, s0, busy, valid, sample} !== {4'b0000, exp_sample}) begin
      n_fail++; $display("FAIL scan_idle: got %b expected %b", {s1, s0, busy, valid, sample}, {4'b0000, exp_sample});
    end
`ifdef MUX_SCAN_CHANGE_EN
    n_assert++;
    if (changed !== 1'b0) begin
      n_fail++; $display("FAIL scan_changed_low: got %b expected 0", changed);
    end
`endif
  endtask

  task automatic test_basic_scan();
    c = 4'b0101;
    run_scan(4'b0101, 1'b1);
  endtask

  task automatic test_abort();
    int pulses;
    c = 4'b0101;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    n_assert++;
    if ({s1, s0, busy} !== 3'b101) begin
      n_fail++; $display("FAIL abort_pre: sel/busy got %b expected 101", {s1, s0, busy});
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_assert++;
    if ({s1, s0, busy, valid} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_idle: got %b expected 0000", {s1, s0, busy, valid});
    end
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (valid === 1'b1) pulses++;
    end
    n_assert++;
    if (pulses !== 0) begin
      n_fail++; $display("FAIL abort_novalid: got %0d pulses expected 0", pulses);
    end
    n_assert++;
    if (sample !== 4'b0101) begin
      n_fail++; $display("FAIL abort_sample: got %b expected 0101", sample);
    end
    run_scan(4'b0101, 1'b0);
  endtask

  task automatic test_new_inputs();
    c = 4'b0110;
    run_scan(4'b0110, 1'b1);
    run_scan(4'b0110, 1'b0);
  endtask

  task automatic test_start_ignored();
    int pulses;
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    n_assert++;
    if ({s1, s0, busy} !== 3'b000) begin
      n_fail++; $display("FAIL start_abort: sel/busy got %b expected 000", {s1, s0, busy});
    end
    c = 4'b1100;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      if (j == 3 || j == 8) start = 1'b1;
      else                  start = 1'b0;
      if (valid === 1'b1) pulses++;
      @(negedge clk);
    end
    start = 1'b0;
    n_assert++;
    if (pulses !== 1) begin
      n_fail++; $display("FAIL start_midscan: got %0d valid pulses expected 1", pulses);
    end
    n_assert++;
    if (sample !== 4'b1100) begin
      n_fail++; $display("FAIL start_midscan_sample: got %b expected 1100", sample);
    end
  endtask

  task automatic test_reset_midscan();
    c = 4'b1111;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({s1, s0, busy} !== 3'b011) begin
      n_fail++; $display("FAIL rst_pre: sel/busy got %b expected 011", {s1, s0, busy});
    end
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    n_assert++;
    if ({s1, s0, busy, valid, sample} !== 8'h00) begin
      n_fail++; $display("FAIL rst_midscan: got %b expected 00000000", {s1, s0, busy, valid, sample});
    end
`ifdef MUX_SCAN_CHANGE_EN
    n_assert++;
    if (changed !== 1'b0) begin
      n_fail++; $display("FAIL rst_changed: got %b expected 0", changed);
    end
`endif
    repeat (3) @(negedge clk);
    n_assert++;
    if ({busy, valid} !== 2'b00) begin
      n_fail++; $display("FAIL rst_stays_idle: busy/valid got %b expected 00", {busy, valid});
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    c3 = 4'b1001;
    @(negedge clk) start3 = 1'b1;
    pulses = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (valid3 === 1'b1) begin
        n_assert++;
        if (j !== 16 + 18 * pulses) begin
          n_fail++; $display("FAIL b2b_pos%0d: valid at cycle %0d expected %0d", pulses, j, 16 + 18 * pulses);
        end
        n_assert++;
        if (sample3 !== 4'b1001) begin
          n_fail++; $display("FAIL b2b_sample%0d: got %b expected 1001", pulses, sample3);
        end
        pulses++;
      end
      if (j == 40) start3 = 1'b0;
    end
    n_assert++;
    if (pulses !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d pulses expected 3", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_abort();
    test_new_inputs();
    test_start_ignored();
    test_reset_midscan();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
